// File: rtl/systolic_seq_ctrl_pkg.sv
// rtl/systolic_seq_ctrl_pkg.sv - shared state encoding and drain-length helper for the systolic sequencer
package systolic_seq_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } seq_state_t;

   // Drain covers read latency, lane skew, array propagation and the product register.
   function automatic int drain_len(input int rows, input int columns);
      return rows + columns;
   endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// rtl/systolic_skew_lane.sv - DEPTH-stage delay line for one array lane; emits zero whenever the carried element is invalid
module systolic_skew_lane #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] lane_data,
   input  logic             lane_valid,
   output logic [WIDTH-1:0] skew_data
);

   if (DEPTH == 0) begin : g_pass
      logic unused_clk;
      assign unused_clk = clock ^ reset;
      assign skew_data  = lane_valid ? lane_data : '0;
   end else begin : g_shift
      logic [WIDTH-1:0] data_q [DEPTH];
      logic [DEPTH-1:0] valid_q;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            for (int s = 0; s < DEPTH; s++) begin
               data_q[s] <= '0;
            end
            valid_q <= '0;
         end else begin
            // Invalid data is zeroed on entry so stale RAM contents never travel down the line.
            data_q[0]  <= lane_valid ? lane_data : '0;
            valid_q[0] <= lane_valid;
            for (int s = 1; s < DEPTH; s++) begin
               data_q[s]  <= data_q[s-1];
               valid_q[s] <= valid_q[s-1];
            end
         end
      end

      assign skew_data = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - sequencer streaming skewed A/B operands into a ROWS x COLUMNS systolic array
module systolic_seq_ctrl
   import systolic_seq_ctrl_pkg::*;
#(
   parameter int ROWS    = 2,
   parameter int COLUMNS = 2,
   parameter int WIDTH   = 8,
   parameter int KW      = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [KW-1:0]            k_len,
   output logic                     busy,
   output logic                     done,
   output logic                     rd_en,
   output logic [KW-1:0]            rd_addr,
   input  logic [ROWS*WIDTH-1:0]    a_rdata,
   input  logic [COLUMNS*WIDTH-1:0] b_rdata,
   output logic [ROWS*WIDTH-1:0]    a_out,
   output logic [COLUMNS*WIDTH-1:0] b_out,
   output logic                     acc_clear,
   output logic                     acc_en
);

   localparam int             DRAIN_LEN  = drain_len(ROWS, COLUMNS);
   localparam int             DW         = $clog2(DRAIN_LEN) + 1;
   localparam logic [DW-1:0]  DRAIN_LAST = DW'(DRAIN_LEN - 1);

   seq_state_t               state;
   logic [KW-1:0]            k_last;
   logic [DW-1:0]            drain_cnt;
   logic                     data_valid;
   logic [ROWS*WIDTH-1:0]    a_skew;
   logic [COLUMNS*WIDTH-1:0] b_skew;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         k_last    <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         acc_clear <= 1'b0;
         acc_en    <= 1'b0;
      end else begin
         acc_clear <= 1'b0;
         done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (k_len != '0) begin
                     state     <= S_LOAD;
                     k_last    <= k_len - KW'(1);
                     rd_en     <= 1'b1;
                     rd_addr   <= '0;
                     acc_clear <= 1'b1;
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (data_valid) begin
                  acc_en <= 1'b1;
               end
               // Comparing against K-1 keeps K = 2^KW-1 from wrapping the address.
               if (rd_addr == k_last) begin
                  state     <= S_DRAIN;
                  rd_en     <= 1'b0;
                  rd_addr   <= '0;
                  drain_cnt <= '0;
               end else begin
                  rd_addr <= rd_addr + KW'(1);
               end
            end
            S_DRAIN: begin
               if (data_valid) begin
                  acc_en <= 1'b1;
               end
               if (drain_cnt == DRAIN_LAST) begin
                  state  <= S_DONE;
                  done   <= 1'b1;
                  acc_en <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy   <= 1'b0;
               acc_en <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // RAM data lags rd_en by one cycle; this tag marks the cycles it is meaningful.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_valid <= 1'b0;
      end else begin
         data_valid <= rd_en;
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
      systolic_skew_lane #(
         .WIDTH (WIDTH),
         .DEPTH (i)
      ) u_lane (
         .clock      (clock),
         .reset      (reset),
         .lane_data  (a_rdata[(i+1)*WIDTH-1 -: WIDTH]),
         .lane_valid (data_valid),
         .skew_data  (a_skew[(i+1)*WIDTH-1 -: WIDTH])
      );
   end

   for (genvar j = 0; j < COLUMNS; j++) begin : g_b_lane
      systolic_skew_lane #(
         .WIDTH (WIDTH),
         .DEPTH (j)
      ) u_lane (
         .clock      (clock),
         .reset      (reset),
         .lane_data  (b_rdata[(j+1)*WIDTH-1 -: WIDTH]),
         .lane_valid (data_valid),
         .skew_data  (b_skew[(j+1)*WIDTH-1 -: WIDTH])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_out <= '0;
         b_out <= '0;
      end else begin
         a_out <= a_skew;
         b_out <= b_skew;
      end
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - scoreboard bench for systolic_seq_ctrl with operand RAM and accumulating array models
module tb_systolic_seq_ctrl;

   localparam int ROWS    = 2;
   localparam int COLUMNS = 2;
   localparam int WIDTH   = 8;
   localparam int KW      = 8;
   localparam int RC      = ROWS + COLUMNS;

   logic                     clock;
   logic                     reset;
   logic                     start;
   logic [KW-1:0]            k_len;
   logic                     busy;
   logic                     done;
   logic                     rd_en;
   logic [KW-1:0]            rd_addr;
   logic [ROWS*WIDTH-1:0]    a_rdata;
   logic [COLUMNS*WIDTH-1:0] b_rdata;
   logic [ROWS*WIDTH-1:0]    a_out;
   logic [COLUMNS*WIDTH-1:0] b_out;
   logic                     acc_clear;
   logic                     acc_en;

   logic [ROWS*WIDTH-1:0]    a_mem [256];
   logic [COLUMNS*WIDTH-1:0] b_mem [256];

   typedef struct {
      int                       cyc;
      logic                     busy;
      logic                     done;
      logic                     rd_en;
      logic [KW-1:0]            rd_addr;
      logic [ROWS*WIDTH-1:0]    a;
      logic [COLUMNS*WIDTH-1:0] b;
      logic                     acc_clear;
      logic                     acc_en;
   } exp_t;

   exp_t sb [$];
   int   checks;
   int   errors;

   systolic_seq_ctrl #(
      .ROWS    (ROWS),
      .COLUMNS (COLUMNS),
      .WIDTH   (WIDTH),
      .KW      (KW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .k_len     (k_len),
      .busy      (busy),
      .done      (done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .a_rdata   (a_rdata),
      .b_rdata   (b_rdata),
      .a_out     (a_out),
      .b_out     (b_out),
      .acc_clear (acc_clear),
      .acc_en    (acc_en)
   );

   always #5 clock = ~clock;

   // One-cycle-latency RAM; garbage appears on idle cycles so leaks show up.
   always @(posedge clock) begin
      if (rd_en) begin
         a_rdata <= a_mem[rd_addr];
         b_rdata <= b_mem[rd_addr];
      end else begin
         a_rdata <= (ROWS*WIDTH)'($urandom);
         b_rdata <= (COLUMNS*WIDTH)'($urandom);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_example();
      for (int k = 0; k < 3; k++) begin
         a_mem[k] = {WIDTH'(2*k + 2), WIDTH'(2*k + 1)};
         b_mem[k] = {WIDTH'(2*k + 8), WIDTH'(2*k + 7)};
      end
   endtask

   task automatic fill_random();
      for (int k = 0; k < 256; k++) begin
         a_mem[k] = (ROWS*WIDTH)'($urandom);
         b_mem[k] = (COLUMNS*WIDTH)'($urandom);
      end
   endtask

   task automatic push_expected(input int k);
      exp_t e;
      int   n;
      int   kk;
      n = (k == 0) ? 2 : k + RC + 2;
      for (int c = 1; c <= n; c++) begin
         e.cyc       = c;
         e.a         = '0;
         e.b         = '0;
         if (k == 0) begin
            e.busy      = (c == 1);
            e.done      = (c == 1);
            e.rd_en     = 1'b0;
            e.rd_addr   = '0;
            e.acc_clear = 1'b0;
            e.acc_en    = 1'b0;
         end else begin
            e.busy      = (c <= k + RC + 1);
            e.done      = (c == k + RC + 1);
            e.rd_en     = (c <= k);
            e.rd_addr   = (c <= k) ? KW'(c - 1) : '0;
            e.acc_clear = (c == 1);
            e.acc_en    = (c >= 3) && (c <= k + RC);
            for (int i = 0; i < ROWS; i++) begin
               kk = c - 3 - i;
               if (kk >= 0 && kk < k) e.a[i*WIDTH +: WIDTH] = a_mem[kk][i*WIDTH +: WIDTH];
            end
            for (int j = 0; j < COLUMNS; j++) begin
               kk = c - 3 - j;
               if (kk >= 0 && kk < k) e.b[j*WIDTH +: WIDTH] = b_mem[kk][j*WIDTH +: WIDTH];
            end
         end
         sb.push_back(e);
      end
   endtask

   // mode 0: plain run, mode 1: extra starts in cycles 2 and 8, mode 2: reset in cycle 4
   task automatic run(input int k, input int mode);
      exp_t             e;
      logic [31:0]      acc [ROWS][COLUMNS];
      logic [WIDTH-1:0] ar  [ROWS][COLUMNS];
      logic [WIDTH-1:0] br  [ROWS][COLUMNS];
      logic [WIDTH-1:0] na  [ROWS][COLUMNS];
      logic [WIDTH-1:0] nb  [ROWS][COLUMNS];
      logic [WIDTH-1:0] ain;
      logic [WIDTH-1:0] bin;
      logic [31:0]      sum;
      for (int i = 0; i < ROWS; i++) begin
         for (int j = 0; j < COLUMNS; j++) begin
            acc[i][j] = 32'hdead_beef;
            ar[i][j]  = '0;
            br[i][j]  = '0;
         end
      end
      push_expected(k);
      start = 1'b1;
      k_len = KW'(k);
      while (sb.size() > 0) begin
         @(negedge clock);
         e = sb.pop_front();
         check($sformatf("busy c%0d k%0d", e.cyc, k), 64'(busy), 64'(e.busy));
         check($sformatf("done c%0d k%0d", e.cyc, k), 64'(done), 64'(e.done));
         check($sformatf("rd_en c%0d k%0d", e.cyc, k), 64'(rd_en), 64'(e.rd_en));
         check($sformatf("rd_addr c%0d k%0d", e.cyc, k), 64'(rd_addr), 64'(e.rd_addr));
         check($sformatf("acc_clear c%0d k%0d", e.cyc, k), 64'(acc_clear), 64'(e.acc_clear));
         check($sformatf("acc_en c%0d k%0d", e.cyc, k), 64'(acc_en), 64'(e.acc_en));
         check($sformatf("a_out c%0d k%0d", e.cyc, k), 64'(a_out), 64'(e.a));
         check($sformatf("b_out c%0d k%0d", e.cyc, k), 64'(b_out), 64'(e.b));
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLUMNS; j++) begin
               ain = (j == 0) ? a_out[i*WIDTH +: WIDTH] : ar[i][j-1];
               bin = (i == 0) ? b_out[j*WIDTH +: WIDTH] : br[i-1][j];
               if (acc_clear) acc[i][j] = '0;
               if (acc_en) acc[i][j] = acc[i][j] + 32'(ain) * 32'(bin);
               na[i][j] = ain;
               nb[i][j] = bin;
            end
         end
         ar = na;
         br = nb;
         start = (mode == 1) && (e.cyc == 2 || e.cyc == 8);
         if (mode == 2 && e.cyc == 4) begin
            reset = 1'b0;
            sb.delete();
            #1;
            check("abort busy", 64'(busy), 64'd0);
            check("abort rd_en", 64'(rd_en), 64'd0);
            check("abort acc_en", 64'(acc_en), 64'd0);
            check("abort a_out", 64'(a_out), 64'd0);
            check("abort b_out", 64'(b_out), 64'd0);
            for (int c = 0; c < 3; c++) begin
               @(negedge clock);
               check($sformatf("abort done %0d", c), 64'(done), 64'd0);
               check($sformatf("abort busy %0d", c), 64'(busy), 64'd0);
            end
            reset = 1'b1;
            return;
         end
      end
      start = 1'b0;
      if (k > 0) begin
         for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLUMNS; j++) begin
               sum = '0;
               for (int kk = 0; kk < k; kk++) begin
                  sum = sum + 32'(a_mem[kk][i*WIDTH +: WIDTH]) * 32'(b_mem[kk][j*WIDTH +: WIDTH]);
               end
               check($sformatf("C[%0d][%0d] k%0d", i, j, k), 64'(acc[i][j]), 64'(sum));
            end
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      clock   = 1'b0;
      reset   = 1'b0;
      start   = 1'b0;
      k_len   = '0;
      a_rdata = '0;
      b_rdata = '0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         check($sformatf("idle busy %0d", c), 64'(busy), 64'd0);
         check($sformatf("idle done %0d", c), 64'(done), 64'd0);
         check($sformatf("idle rd_en %0d", c), 64'(rd_en), 64'd0);
         check($sformatf("idle rd_addr %0d", c), 64'(rd_addr), 64'd0);
         check($sformatf("idle acc %0d", c), 64'({acc_clear, acc_en}), 64'd0);
         check($sformatf("idle a_out %0d", c), 64'(a_out), 64'd0);
         check($sformatf("idle b_out %0d", c), 64'(b_out), 64'd0);
      end
      fill_example();
      run(3, 0);
      run(0, 0);
      run(3, 1);
      run(3, 0);
      run(3, 2);
      run(3, 0);
      fill_random();
      run(1, 0);
      run(2, 0);
      run(5, 0);
      run(255, 0);
      repeat (2) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
